// File: rtl/hawk_video_rx.sv
// Receive side of the Hawk FVAL/LVAL/DATA parallel video bus: samples the bus,
// tracks frame/line structure, emits a qualified pixel stream with X/Y
// coordinates, SOF/EOL/EOF strobes, geometry measurements and sticky errors.
`timescale 1ns/1ps

module hawk_video_rx #(
    parameter int unsigned DW         = 14,
    parameter int unsigned EXP_WIDTH  = 640,
    parameter int unsigned EXP_HEIGHT = 15,
    parameter int unsigned XW         = 12,
    parameter int unsigned YW         = 12
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          FVAL,
    input  logic          LVAL,
    input  logic [DW-1:0] DATA,
    input  logic          CLR_ERR,
    output logic [DW-1:0] PIX_DATA,
    output logic          PIX_VALID,
    output logic [XW-1:0] PIX_X,
    output logic [YW-1:0] PIX_Y,
    output logic          SOF,
    output logic          EOL,
    output logic          EOF,
    output logic [XW-1:0] LAST_WIDTH,
    output logic [YW-1:0] LAST_HEIGHT,
    output logic          FRAME_OK,
    output logic [15:0]   FRAME_CNT,
    output logic          ERR_LEN,
    output logic          ERR_HGT,
    output logic          ERR_SYNC
);

    localparam logic [XW-1:0] X_MAX = '1;
    localparam logic [YW-1:0] Y_MAX = '1;
    localparam logic [XW-1:0] EXP_W = XW'(EXP_WIDTH);
    localparam logic [YW-1:0] EXP_H = YW'(EXP_HEIGHT);

    typedef enum logic [1:0] {
        WAIT_SYNC,
        IDLE,
        FRAME,
        LINE
    } state_t;

    state_t        state;
    state_t        next_state;

    logic          f1, l1, f2, l2;
    logic [DW-1:0] d1;
    logic          primed;

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          acc;

    logic          pix_c;
    logic          frame_start_c;
    logic          line_start_c;
    logic          line_end_c;
    logic          frame_end_c;
    logic          sync_err_c;

    logic [XW-1:0] x_cur;
    logic [YW-1:0] y_cur;
    logic [YW-1:0] y_inc;
    logic [YW-1:0] height_c;
    logic          width_bad_c;
    logic          height_bad_c;
    logic          acc_line_c;

    // Input sampling; primed marks that f1 holds a real bus sample.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            f1     <= 1'b0;
            l1     <= 1'b0;
            f2     <= 1'b0;
            l2     <= 1'b0;
            d1     <= '0;
            primed <= 1'b0;
        end else begin
            f1     <= FVAL;
            l1     <= LVAL;
            d1     <= DATA;
            f2     <= f1;
            l2     <= l1;
            primed <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state <= WAIT_SYNC;
        end else begin
            state <= next_state;
        end
    end

    // Next state and per-cycle frame/line events from the sampled bus.
    always_comb begin
        next_state    = state;
        pix_c         = 1'b0;
        frame_start_c = 1'b0;
        line_start_c  = 1'b0;
        line_end_c    = 1'b0;
        frame_end_c   = 1'b0;
        sync_err_c    = l1 & ~f1;
        case (state)
            WAIT_SYNC: begin
                if (primed && !f1) begin
                    next_state = IDLE;
                end
            end
            IDLE: begin
                if (f1 && !f2) begin
                    frame_start_c = 1'b1;
                    if (l1) begin
                        line_start_c = 1'b1;
                        pix_c        = 1'b1;
                        next_state   = LINE;
                    end else begin
                        next_state   = FRAME;
                    end
                end
            end
            FRAME: begin
                if (!f1) begin
                    frame_end_c = 1'b1;
                    next_state  = IDLE;
                end else if (l1 && !l2) begin
                    line_start_c = 1'b1;
                    pix_c        = 1'b1;
                    next_state   = LINE;
                end
            end
            LINE: begin
                if (!f1) begin
                    // Truncated line: close the line and the frame together.
                    line_end_c  = 1'b1;
                    frame_end_c = 1'b1;
                    next_state  = IDLE;
                end else if (l1) begin
                    pix_c = 1'b1;
                end else begin
                    line_end_c = 1'b1;
                    next_state = FRAME;
                end
            end
            default: next_state = WAIT_SYNC;
        endcase
    end

    // Coordinates, geometry checks and frame-accumulator update for this cycle.
    always_comb begin
        x_cur        = line_start_c ? '0 : x;
        y_cur        = frame_start_c ? '0 : y;
        y_inc        = (y == Y_MAX) ? y : y + YW'(1);
        width_bad_c  = line_end_c && ((x != EXP_W) || (x == X_MAX));
        acc_line_c   = (frame_start_c | acc) & ~width_bad_c;
        height_c     = line_end_c ? y_inc : y_cur;
        height_bad_c = frame_end_c && ((height_c != EXP_H) || (height_c == Y_MAX));
    end

    // Line/frame counters and per-frame OK accumulator.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            x   <= '0;
            y   <= '0;
            acc <= 1'b0;
        end else begin
            if (pix_c) begin
                x <= (x_cur == X_MAX) ? x_cur : x_cur + XW'(1);
            end
            if (frame_start_c) begin
                y <= '0;
            end else if (line_end_c) begin
                y <= y_inc;
            end
            if (frame_start_c || line_end_c) begin
                acc <= acc_line_c;
            end
        end
    end

    // Registered pixel stream and strobes.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            PIX_DATA  <= '0;
            PIX_VALID <= 1'b0;
            PIX_X     <= '0;
            PIX_Y     <= '0;
            SOF       <= 1'b0;
            EOL       <= 1'b0;
            EOF       <= 1'b0;
        end else begin
            PIX_VALID <= pix_c;
            SOF       <= line_start_c && (y_cur == '0);
            EOL       <= line_end_c;
            EOF       <= frame_end_c;
            if (pix_c) begin
                PIX_DATA <= d1;
                PIX_X    <= x_cur;
                PIX_Y    <= y_cur;
            end
        end
    end

    // Geometry results, frame counter and sticky error flags.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            LAST_WIDTH  <= '0;
            LAST_HEIGHT <= '0;
            FRAME_OK    <= 1'b0;
            FRAME_CNT   <= '0;
            ERR_LEN     <= 1'b0;
            ERR_HGT     <= 1'b0;
            ERR_SYNC    <= 1'b0;
        end else begin
            if (line_end_c) begin
                LAST_WIDTH <= x;
            end
            if (frame_end_c) begin
                LAST_HEIGHT <= height_c;
                FRAME_OK    <= acc_line_c & ~height_bad_c;
                FRAME_CNT   <= FRAME_CNT + 16'd1;
            end
            ERR_LEN  <= (ERR_LEN  & ~CLR_ERR) | width_bad_c;
            ERR_HGT  <= (ERR_HGT  & ~CLR_ERR) | height_bad_c;
            ERR_SYNC <= (ERR_SYNC & ~CLR_ERR) | sync_err_c;
        end
    end

endmodule

// File: tb/tb_hawk_video_rx.sv
// Bench for hawk_video_rx: frame-scenario table plus hand sequences for
// mid-frame reset release, truncated frame, sync error and async reset.
`timescale 1ns/1ps

module tb_hawk_video_rx;

    localparam int unsigned DW = 14;
    localparam int unsigned XW = 12;
    localparam int unsigned YW = 12;

    logic          CLK = 1'b0;
    logic          Reset;
    logic          FVAL;
    logic          LVAL;
    logic [DW-1:0] DATA;
    logic          CLR_ERR;
    logic [DW-1:0] PIX_DATA;
    logic          PIX_VALID;
    logic [XW-1:0] PIX_X;
    logic [YW-1:0] PIX_Y;
    logic          SOF;
    logic          EOL;
    logic          EOF;
    logic [XW-1:0] LAST_WIDTH;
    logic [YW-1:0] LAST_HEIGHT;
    logic          FRAME_OK;
    logic [15:0]   FRAME_CNT;
    logic          ERR_LEN;
    logic          ERR_HGT;
    logic          ERR_SYNC;

    hawk_video_rx dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .FVAL       (FVAL),
        .LVAL       (LVAL),
        .DATA       (DATA),
        .CLR_ERR    (CLR_ERR),
        .PIX_DATA   (PIX_DATA),
        .PIX_VALID  (PIX_VALID),
        .PIX_X      (PIX_X),
        .PIX_Y      (PIX_Y),
        .SOF        (SOF),
        .EOL        (EOL),
        .EOF        (EOF),
        .LAST_WIDTH (LAST_WIDTH),
        .LAST_HEIGHT(LAST_HEIGHT),
        .FRAME_OK   (FRAME_OK),
        .FRAME_CNT  (FRAME_CNT),
        .ERR_LEN    (ERR_LEN),
        .ERR_HGT    (ERR_HGT),
        .ERR_SYNC   (ERR_SYNC)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [DW-1:0] data;
        int            x;
        int            y;
        bit            sof;
    } pix_t;

    typedef struct {
        int lines;
        int short_line;
        int short_len;
        int gap;
        bit clr;
        int exp_h;
        int exp_w;
        bit exp_ok;
        bit exp_el;
        bit exp_eh;
        int exp_cnt;
        int exp_sof;
        int exp_eol;
        int exp_pix;
    } row_t;

    pix_t pix_q[$];
    int   width_q[$];

    int checks = 0;
    int passed = 0;
    int n_pix, n_sof, n_eol, n_eof, n_eol_eof;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic reset_counts();
        n_pix = 0; n_sof = 0; n_eol = 0; n_eof = 0; n_eol_eof = 0;
    endtask

    task automatic step(input bit f, input bit l, input logic [DW-1:0] d);
        @(negedge CLK);
        FVAL = f;
        LVAL = l;
        DATA = d;
    endtask

    task automatic clr_pulse();
        @(negedge CLK);
        CLR_ERR = 1'b1;
        @(negedge CLK);
        CLR_ERR = 1'b0;
    endtask

    // One line of len pixels at line index y, expected pixels queued.
    task automatic drive_line(input int y, input int len);
        logic [DW-1:0] d;
        for (int p = 0; p < len; p++) begin
            d = DW'($urandom);
            step(1'b1, 1'b1, d);
            pix_q.push_back('{data: d, x: p, y: y, sof: (y == 0 && p == 0)});
        end
        width_q.push_back(len);
    endtask

    task automatic run_frame(input int n_lines, input int short_line, input int short_len, input int gap);
        int len;
        repeat (gap) step(1'b1, 1'b0, '0);
        for (int i = 0; i < n_lines; i++) begin
            len = (i == short_line) ? short_len : 640;
            drive_line(i, len);
            repeat (gap) step(1'b1, 1'b0, '0);
        end
        step(1'b0, 1'b0, '0);
        repeat (20) step(1'b0, 1'b0, '0);
    endtask

    // Scoreboard and strobe counters, sampled away from the active edge.
    always @(negedge CLK) begin
        pix_t e;
        if (!Reset) begin
            if (PIX_VALID) begin
                n_pix++;
                if (pix_q.size() == 0) begin
                    check("pix_unexpected", 1, 0);
                end else begin
                    e = pix_q.pop_front();
                    check($sformatf("pix x%0d y%0d {data,x,y,sof}", e.x, e.y),
                          {PIX_DATA, PIX_X, PIX_Y, SOF},
                          {e.data, XW'(e.x), YW'(e.y), e.sof});
                end
            end
            if (SOF && !PIX_VALID) check("sof_without_pix", 1, 0);
            if (SOF) n_sof++;
            if (EOL) begin
                n_eol++;
                if (width_q.size() == 0) check("eol_unexpected", 1, 0);
                else check("last_width_at_eol", LAST_WIDTH, width_q.pop_front());
            end
            if (EOF) n_eof++;
            if (EOL && EOF) n_eol_eof++;
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    row_t rows[5];
    logic [DW-1:0] d;

    initial begin
        rows[0] = '{15, -1,   0, 100, 1'b0, 15, 640, 1'b1, 1'b0, 1'b0, 1, 1, 15, 9600};
        rows[1] = '{15,  7, 639,  20, 1'b0, 15, 640, 1'b0, 1'b1, 1'b0, 2, 1, 15, 9599};
        rows[2] = '{15, -1,   0,  20, 1'b0, 15, 640, 1'b1, 1'b1, 1'b0, 3, 1, 15, 9600};
        rows[3] = '{14, -1,   0,  20, 1'b1, 14, 640, 1'b0, 1'b0, 1'b1, 4, 1, 14, 8960};
        rows[4] = '{ 0, -1,   0,  20, 1'b0,  0, 640, 1'b0, 1'b0, 1'b1, 5, 0,  0,    0};

        Reset = 1'b1; FVAL = 1'b0; LVAL = 1'b0; DATA = '0; CLR_ERR = 1'b0;
        reset_counts();
        repeat (3) @(negedge CLK);
        check("reset pix outputs", {PIX_DATA, PIX_VALID, PIX_X, PIX_Y, SOF, EOL, EOF}, 0);
        check("reset status outputs",
              {LAST_WIDTH, LAST_HEIGHT, FRAME_OK, FRAME_CNT, ERR_LEN, ERR_HGT, ERR_SYNC}, 0);
        Reset = 1'b0;
        repeat (5) step(1'b0, 1'b0, '0);

        // Frame scenarios: clean, short line, clean after error, 14 lines, empty frame.
        for (int r = 0; r < 5; r++) begin
            if (rows[r].clr) begin
                clr_pulse();
                check($sformatf("row%0d err_len after clr", r), ERR_LEN, 0);
                check($sformatf("row%0d frame_ok kept by clr", r), FRAME_OK, rows[r-1].exp_ok);
            end
            reset_counts();
            run_frame(rows[r].lines, rows[r].short_line, rows[r].short_len, rows[r].gap);
            check($sformatf("row%0d sof count", r), n_sof, rows[r].exp_sof);
            check($sformatf("row%0d eol count", r), n_eol, rows[r].exp_eol);
            check($sformatf("row%0d eof count", r), n_eof, 1);
            check($sformatf("row%0d pix count", r), n_pix, rows[r].exp_pix);
            check($sformatf("row%0d last_height", r), LAST_HEIGHT, rows[r].exp_h);
            check($sformatf("row%0d last_width", r), LAST_WIDTH, rows[r].exp_w);
            check($sformatf("row%0d frame_ok", r), FRAME_OK, rows[r].exp_ok);
            check($sformatf("row%0d frame_cnt", r), FRAME_CNT, rows[r].exp_cnt);
            check($sformatf("row%0d err_len", r), ERR_LEN, rows[r].exp_el);
            check($sformatf("row%0d err_hgt", r), ERR_HGT, rows[r].exp_eh);
            check($sformatf("row%0d err_sync", r), ERR_SYNC, 0);
            check($sformatf("row%0d pending pixels", r), pix_q.size(), 0);
        end

        // FVAL falls on pixel 300 of line 3.
        clr_pulse();
        check("trunc err_hgt cleared", ERR_HGT, 0);
        reset_counts();
        repeat (20) step(1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            drive_line(i, 640);
            repeat (20) step(1'b1, 1'b0, '0);
        end
        drive_line(3, 300);
        step(1'b0, 1'b0, '0);
        repeat (20) step(1'b0, 1'b0, '0);
        check("trunc eol count", n_eol, 4);
        check("trunc eof count", n_eof, 1);
        check("trunc eol+eof same cycle", n_eol_eof, 1);
        check("trunc pix count", n_pix, 2220);
        check("trunc last_width", LAST_WIDTH, 300);
        check("trunc last_height", LAST_HEIGHT, 4);
        check("trunc err_len", ERR_LEN, 1);
        check("trunc err_hgt", ERR_HGT, 1);
        check("trunc frame_ok", FRAME_OK, 0);
        check("trunc frame_cnt", FRAME_CNT, 6);

        // LVAL pulse without FVAL.
        clr_pulse();
        reset_counts();
        check("sync err cleared", ERR_SYNC, 0);
        repeat (10) step(1'b0, 1'b1, DW'($urandom));
        step(1'b0, 1'b0, '0);
        repeat (5) step(1'b0, 1'b0, '0);
        check("sync err_sync", ERR_SYNC, 1);
        check("sync pix count", n_pix, 0);
        check("sync strobes", n_sof + n_eol + n_eof, 0);
        check("sync frame_cnt", FRAME_CNT, 6);

        // Async reset in the middle of a line.
        repeat (20) step(1'b1, 1'b0, '0);
        for (int p = 0; p < 50; p++) begin
            d = DW'($urandom);
            step(1'b1, 1'b1, d);
            pix_q.push_back('{data: d, x: p, y: 0, sof: (p == 0)});
        end
        check("midline pix_valid before reset", PIX_VALID, 1);
        #3;
        Reset = 1'b1;
        #1;
        check("async reset pix outputs", {PIX_DATA, PIX_VALID, PIX_X, PIX_Y, SOF, EOL, EOF}, 0);
        check("async reset status outputs",
              {LAST_WIDTH, LAST_HEIGHT, FRAME_OK, FRAME_CNT, ERR_LEN, ERR_HGT, ERR_SYNC}, 0);
        pix_q.delete();
        width_q.delete();

        // Reset released while a frame is already in progress.
        reset_counts();
        repeat (5) step(1'b1, 1'b0, '0);
        for (int p = 0; p < 640; p++) begin
            step(1'b1, 1'b1, DW'($urandom));
            if (p == 100) Reset = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            repeat (20) step(1'b1, 1'b0, '0);
            for (int p = 0; p < 640; p++) step(1'b1, 1'b1, DW'($urandom));
        end
        repeat (20) step(1'b1, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        repeat (20) step(1'b0, 1'b0, '0);
        check("midframe release pix count", n_pix, 0);
        check("midframe release strobes", n_sof + n_eol + n_eof, 0);
        check("midframe release frame_cnt", FRAME_CNT, 0);
        run_frame(15, -1, 0, 20);
        check("relock frame_cnt", FRAME_CNT, 1);
        check("relock pix count", n_pix, 9600);
        check("relock sof count", n_sof, 1);
        check("relock eol count", n_eol, 15);
        check("relock eof count", n_eof, 1);
        check("relock frame_ok", FRAME_OK, 1);
        check("relock last_height", LAST_HEIGHT, 15);
        check("relock errors", {ERR_LEN, ERR_HGT, ERR_SYNC}, 0);
        check("relock pending pixels", pix_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
